sys_ctrl_tx: RTL and testbench
==============================

SYS_CTRL_TX -- requirements
Module: sys_ctrl_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: UART byte width; ALU result width is 2*DATA_WIDTH.
REQ-002 SHALL have port clk  in  1  system clock.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ALU_OUT  in  2*DATA_WIDTH  ALU result.
REQ-005 SHALL have port OUT_Valid  in  1  single-cycle pulse; ALU_OUT is valid.
REQ-006 SHALL have port RdData  in  DATA_WIDTH  register-file read data.
REQ-007 SHALL have port RdData_Valid  in  1  single-cycle pulse; RdData is valid.
REQ-008 SHALL have port TX_Busy  in  1  UART TX busy, already synchronized to clk.
REQ-009 SHALL have port TX_P_Data  out  DATA_WIDTH  byte presented to UART TX.
REQ-010 SHALL have port TX_D_VLD  out  1  byte request to UART TX.
REQ-011 SHALL have port Ovf  out  1  sticky flag: a result was dropped.

Function
REQ-012 SHALL capture RdData on RdData_Valid into a one-deep RD slot, and ALU_OUT on OUT_Valid into a one-deep ALU slot, in every state.
REQ-013 SHALL, when a valid pulse arrives while its slot is full, drop the new value, keep the old one and set Ovf.
REQ-014 SHALL use the FSM states IDLE, RD_SEND, RD_WAIT, LO_SEND, LO_WAIT, HI_SEND, HI_WAIT.
REQ-015 SHALL leave IDLE only when TX_Busy=0 and a slot is full: RD slot first (-> RD_SEND), otherwise ALU slot (-> LO_SEND).
REQ-016 SHALL, when both valid pulses arrive in the same cycle, capture both and send the RD byte first.
REQ-017 SHALL, in any *_SEND state, hold TX_D_VLD=1 and TX_P_Data stable until TX_Busy=1 is sampled, then move to the matching *_WAIT.
REQ-018 SHALL, in any *_WAIT state, hold TX_D_VLD=0 and TX_P_Data stable until TX_Busy=0 is sampled.
REQ-019 SHALL use the following *_WAIT exits: RD_WAIT -> IDLE; LO_WAIT -> HI_SEND; HI_WAIT -> IDLE.
REQ-020 SHALL free a slot on the cycle its last byte enters *_WAIT, so that slot can accept a new capture on the next cycle.
REQ-021 SHALL send LO_SEND with ALU_OUT[DATA_WIDTH-1:0] and HI_SEND with ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-022 SHALL start TX_D_VLD on the first cycle after the IDLE decision (1-cycle latency, registered), with no combinational path from the inputs to the outputs.
REQ-023 SHALL, when TX_Busy=1 in IDLE (link held by another source), keep the slots and wait.
REQ-024 SHALL, when a slot fills in the same cycle it is freed, accept the new value without setting Ovf.

Reset
REQ-025 SHALL on rst=0 immediately force state=IDLE, TX_D_VLD=0, TX_P_Data=0, Ovf=0 and both slots empty, including mid-transfer.
REQ-026 SHALL clear Ovf only by reset.

Configuration
REQ-027 SHALL, with SYS_CTRL_TX_ALU16_EN defined, send the ALU result as a low byte then a high byte, per REQ-019.
REQ-028 SHALL, without SYS_CTRL_TX_ALU16_EN, send only the low byte: LO_WAIT -> IDLE, and HI_SEND/HI_WAIT are not compiled in.

Structure
REQ-029 SHALL take its FSM state encoding localparams and its DATA_WIDTH default from shared package sys_ctrl_pkg.
REQ-030 SHALL instantiate its two slots as sub-module sys_ctrl_tx_slot: a data register, a full flag, capture/free inputs and an overflow pulse output.

Verification
REQ-031 SHALL cover: RdData=8'h5A pulse with TX_Busy low -> TX_P_Data=8'h5A and TX_D_VLD=1 next cycle, held until the emulated UART raises TX_Busy.
REQ-032 SHALL cover: ALU_OUT=16'hBEEF -> bytes 8'hEF then 8'hBE with the macro; only 8'hEF without it.
REQ-033 SHALL cover: RdData=8'h11 and ALU_OUT=16'h2233 in the same cycle -> bytes sent in the order 11, 33, 22, with Ovf=0.
REQ-034 SHALL cover: two RdData pulses (8'h01, 8'h02) while the RD byte is still in RD_SEND -> only 8'h01 sent, Ovf=1.
REQ-035 SHALL cover: rst asserted during LO_WAIT -> TX_D_VLD=0, state IDLE, and the pending high byte is never sent after release.
REQ-036 SHALL cover: TX_Busy held high 50 cycles in IDLE with ALU slot full -> no TX_D_VLD until TX_Busy falls, then 16'hBEEF sent intact.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-control TX path: FSM encodings and widths.
// SYS_CTRL_TX_ALU16_EN enables the ALU high-byte states.
package sys_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ST_W           = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_SEND = 3'd1;
    localparam state_t ST_RD_WAIT = 3'd2;
    localparam state_t ST_LO_SEND = 3'd3;
    localparam state_t ST_LO_WAIT = 3'd4;
`ifdef SYS_CTRL_TX_ALU16_EN
    localparam state_t ST_HI_SEND = 3'd5;
    localparam state_t ST_HI_WAIT = 3'd6;
`endif

    function automatic logic is_send(input state_t s);
        logic r;
        r = (s == ST_RD_SEND) || (s == ST_LO_SEND);
`ifdef SYS_CTRL_TX_ALU16_EN
        r = r || (s == ST_HI_SEND);
`endif
        return r;
    endfunction

endpackage

// File: rtl/sys_ctrl_tx_slot.sv
// One-deep holding slot: captures on a valid pulse, drops and flags when full.
// A capture on the same cycle as a free is accepted without overflow.
module sys_ctrl_tx_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cap,
    input  logic         free,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         ovf
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        ovf    = 1'b0;
        if (free) begin
            full_d = 1'b0;
        end
        if (cap) begin
            if (!full_q || free) begin
                data_d = din;
                full_d = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/sys_ctrl_tx.sv
// Arbitrates register-file reads and ALU results onto the UART TX byte link.
// Define SYS_CTRL_TX_ALU16_EN to send the ALU high byte after the low byte.
module sys_ctrl_tx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic                    TX_Busy,
    output logic [DATA_WIDTH-1:0]   TX_P_Data,
    output logic                    TX_D_VLD,
    output logic                    Ovf
);

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0]   rd_data;
    logic [2*DATA_WIDTH-1:0] alu_data;
    logic                    rd_full, alu_full;
    logic                    rd_free, alu_free;
    logic                    rd_ovf, alu_ovf;

    sys_ctrl_tx_slot #(.W(DATA_WIDTH)) u_rd_slot (
        .clk  (clk),
        .rst  (rst),
        .cap  (RdData_Valid),
        .free (rd_free),
        .din  (RdData),
        .dout (rd_data),
        .full (rd_full),
        .ovf  (rd_ovf)
    );

    sys_ctrl_tx_slot #(.W(2*DATA_WIDTH)) u_alu_slot (
        .clk  (clk),
        .rst  (rst),
        .cap  (OUT_Valid),
        .free (alu_free),
        .din  (ALU_OUT),
        .dout (alu_data),
        .full (alu_full),
        .ovf  (alu_ovf)
    );

    // A slot is released as its last byte is accepted by the UART.
    assign rd_free = (state_q == ST_RD_SEND) && TX_Busy;
`ifdef SYS_CTRL_TX_ALU16_EN
    assign alu_free = (state_q == ST_HI_SEND) && TX_Busy;
`else
    assign alu_free = (state_q == ST_LO_SEND) && TX_Busy;
    logic alu_hi_unused;
    assign alu_hi_unused = ^alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!TX_Busy) begin
                    if (rd_full) begin
                        state_d = ST_RD_SEND;
                    end else if (alu_full) begin
                        state_d = ST_LO_SEND;
                    end
                end
            end
            ST_RD_SEND: if (TX_Busy) state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (!TX_Busy) state_d = ST_IDLE;
            ST_LO_SEND: if (TX_Busy) state_d = ST_LO_WAIT;
`ifdef SYS_CTRL_TX_ALU16_EN
            ST_LO_WAIT: if (!TX_Busy) state_d = ST_HI_SEND;
            ST_HI_SEND: if (TX_Busy) state_d = ST_HI_WAIT;
            ST_HI_WAIT: if (!TX_Busy) state_d = ST_IDLE;
`else
            ST_LO_WAIT: if (!TX_Busy) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        tx_vld_d  = is_send(state_d);
        tx_data_d = tx_data_q;
        case (state_d)
            ST_RD_SEND: tx_data_d = rd_data;
            ST_LO_SEND: tx_data_d = alu_data[DATA_WIDTH-1:0];
`ifdef SYS_CTRL_TX_ALU16_EN
            ST_HI_SEND: tx_data_d = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
            default: tx_data_d = tx_data_q;
        endcase
        ovf_d = ovf_q | rd_ovf | alu_ovf;
    end

    assign TX_P_Data = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Directed bench for sys_ctrl_tx with a small UART TX model on the byte link.
// Expectations follow SYS_CTRL_TX_ALU16_EN when it is defined.
module tb_sys_ctrl_tx;
    import sys_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] ALU_OUT;
    logic        OUT_Valid;
    logic [7:0]  RdData;
    logic        RdData_Valid;
    logic        TX_Busy;
    logic [7:0]  TX_P_Data;
    logic        TX_D_VLD;
    logic        Ovf;

    logic        uart_busy  = 1'b0;
    logic        busy_force = 1'b0;
    logic        uart_en    = 1'b0;
    int          uart_cnt   = 0;
    logic [7:0]  sent[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign TX_Busy = uart_busy | busy_force;

    sys_ctrl_tx #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_Busy      (TX_Busy),
        .TX_P_Data    (TX_P_Data),
        .TX_D_VLD     (TX_D_VLD),
        .Ovf          (Ovf)
    );

    // UART model: takes a byte when requested and stays busy 4 cycles.
    always @(posedge clk) begin
        #1;
        if (uart_busy) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) uart_busy = 1'b0;
        end else if (uart_en && TX_D_VLD) begin
            sent.push_back(TX_P_Data);
            uart_busy = 1'b1;
            uart_cnt  = 4;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < sent.size()) return sent[i];
        return 8'hxx;
    endfunction

    task automatic pulse_rd(input logic [7:0] d);
        RdData       = d;
        RdData_Valid = 1'b1;
        tick();
        RdData_Valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [15:0] d);
        ALU_OUT   = d;
        OUT_Valid = 1'b1;
        tick();
        OUT_Valid = 1'b0;
    endtask

    initial begin
        logic saw;
        int   n;
        ALU_OUT      = '0;
        OUT_Valid    = 1'b0;
        RdData       = '0;
        RdData_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_vld", TX_D_VLD, 0);
        chk("rst_data", TX_P_Data, 0);
        chk("rst_ovf", Ovf, 0);
        chk("rst_state", dut.state_q, ST_IDLE);
        rst = 1'b1;
        tick();

        // Read byte, UART held off so the request must persist
        pulse_rd(8'h5A);
        chk("rd_lat0", TX_D_VLD, 0);
        tick();
        chk("rd_vld", TX_D_VLD, 1);
        chk("rd_data", TX_P_Data, 8'h5A);
        repeat (3) tick();
        chk("rd_hold_vld", TX_D_VLD, 1);
        chk("rd_hold_data", TX_P_Data, 8'h5A);
        sent.delete();
        uart_en = 1'b1;
        repeat (40) tick();
        chk("rd_cnt", sent.size(), 1);
        chk("rd_byte", byte_at(0), 8'h5A);

        // ALU result
        sent.delete();
        pulse_alu(16'hBEEF);
        repeat (40) tick();
`ifdef SYS_CTRL_TX_ALU16_EN
        chk("alu_cnt", sent.size(), 2);
        chk("alu_hi", byte_at(1), 8'hBE);
`else
        chk("alu_cnt", sent.size(), 1);
`endif
        chk("alu_lo", byte_at(0), 8'hEF);

        // Both sources in one cycle
        sent.delete();
        RdData       = 8'h11;
        ALU_OUT      = 16'h2233;
        RdData_Valid = 1'b1;
        OUT_Valid    = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        OUT_Valid    = 1'b0;
        repeat (60) tick();
        chk("both_b0", byte_at(0), 8'h11);
        chk("both_b1", byte_at(1), 8'h33);
`ifdef SYS_CTRL_TX_ALU16_EN
        chk("both_cnt", sent.size(), 3);
        chk("both_b2", byte_at(2), 8'h22);
`else
        chk("both_cnt", sent.size(), 2);
`endif
        chk("both_ovf", Ovf, 0);

        // Second read while the first is still in RD_SEND
        uart_en = 1'b0;
        sent.delete();
        pulse_rd(8'h01);
        tick();
        chk("ovf_send", dut.state_q, ST_RD_SEND);
        pulse_rd(8'h02);
        chk("ovf_set", Ovf, 1);
        uart_en = 1'b1;
        repeat (40) tick();
        chk("ovf_cnt", sent.size(), 1);
        chk("ovf_byte", byte_at(0), 8'h01);
        chk("ovf_sticky", Ovf, 1);
        rst = 1'b0;
        tick();
        chk("ovf_clr", Ovf, 0);
        rst = 1'b1;
        tick();

        // Reset in LO_WAIT drops the pending high byte
        sent.delete();
        pulse_alu(16'hBEEF);
        n = 0;
        while (sent.size() < 1 && n < 30) begin
            tick();
            n++;
        end
        chk("lw_first", sent.size(), 1);
        tick();
        chk("lw_state", dut.state_q, ST_LO_WAIT);
        #1 rst = 1'b0;
        #1;
        chk("lw_rst_vld", TX_D_VLD, 0);
        chk("lw_rst_data", TX_P_Data, 0);
        chk("lw_rst_state", dut.state_q, ST_IDLE);
        tick();
        rst = 1'b1;
        repeat (40) tick();
        chk("lw_cnt", sent.size(), 1);
        chk("lw_byte", byte_at(0), 8'hEF);

        // Link held busy by another source
        sent.delete();
        busy_force = 1'b1;
        pulse_alu(16'hBEEF);
        saw = 1'b0;
        repeat (50) begin
            tick();
            if (TX_D_VLD !== 1'b0) saw = 1'b1;
        end
        chk("busy_novld", saw, 0);
        chk("busy_idle", dut.state_q, ST_IDLE);
        busy_force = 1'b0;
        repeat (40) tick();
        chk("busy_lo", byte_at(0), 8'hEF);
`ifdef SYS_CTRL_TX_ALU16_EN
        chk("busy_cnt", sent.size(), 2);
        chk("busy_hi", byte_at(1), 8'hBE);
`else
        chk("busy_cnt", sent.size(), 1);
`endif

        // Refill on the same cycle the slot is freed
        uart_en = 1'b0;
        sent.delete();
        pulse_rd(8'h77);
        tick();
        chk("fill_vld", TX_D_VLD, 1);
        chk("fill_data", TX_P_Data, 8'h77);
        RdData       = 8'h88;
        RdData_Valid = 1'b1;
        busy_force   = 1'b1;
        tick();
        RdData_Valid = 1'b0;
        busy_force   = 1'b0;
        chk("fill_wait", dut.state_q, ST_RD_WAIT);
        chk("fill_ovf", Ovf, 0);
        uart_en = 1'b1;
        repeat (40) tick();
        chk("fill_cnt", sent.size(), 1);
        chk("fill_byte", byte_at(0), 8'h88);
        chk("fill_ovf_end", Ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
